// File: rtl/uart_ext.sv
// uart_ext -- full-duplex UART with runtime baud divisor, 5..8 data bits,
// optional even/odd parity, one or two TX stop bits, TX/RX FIFOs, an input
// synchroniser and sticky error flags.
//
// Ports
//   clk, rst (async, active-low)       clock and reset
//   baud_div                           clocks per bit (values below 4 act as 4)
//   parity_en, parity_odd, stop2       frame configuration, sampled at frame start
//   tx_data/tx_valid/tx_ready          core -> TX FIFO (ready = FIFO not full)
//   rx_data/rx_valid/rx_ready          RX FIFO -> core, first-word fall-through
//   tx_level, rx_level                 FIFO occupancies
//   tx_busy                            TX FIFO non-empty or frame in flight
//   par_err, frm_err, ovr_err, err_clr sticky error flags and their clear
//   serial_in, serial_out              board pins, both idle high
module uart_ext #(
    parameter int DATA_BITS   = 8,
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               baud_div,
    input  logic                      parity_en,
    input  logic                      parity_odd,
    input  logic                      stop2,
    input  logic [DATA_BITS-1:0]      tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [DATA_BITS-1:0]      rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic                      tx_busy,
    output logic                      par_err,
    output logic                      frm_err,
    output logic                      ovr_err,
    input  logic                      err_clr,
    input  logic                      serial_in,
    output logic                      serial_out
);

    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int BW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_e;

    logic [15:0] div_eff;
    assign div_eff = (baud_div < 16'd4) ? 16'd4 : baud_div;

    // ------------------------------------------------------------------
    // TX FIFO (pointers carry one extra wrap bit to tell full from empty)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] tx_mem_q [TX_DEPTH];
    logic [TXA:0]         tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic                 tx_push, tx_pop, tx_empty, tx_full;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = ({~tx_wr_q[TXA], tx_wr_q[TXA-1:0]} == tx_rd_q);
    assign tx_ready = ~tx_full;
    assign tx_level = tx_wr_q - tx_rd_q;
    assign tx_push  = tx_valid & tx_ready;
    assign tx_head  = tx_mem_q[tx_rd_q[TXA-1:0]];

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q[TXA-1:0]] <= tx_data;
    end

    // ------------------------------------------------------------------
    // TX frame FSM
    // ------------------------------------------------------------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [15:0]          tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic                 tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d;
    logic                 tx_stop2_q, tx_stop2_d, serial_out_q, serial_out_d;
    logic                 tx_tick, tx_done;

    assign tx_tick = (tx_cnt_q == 16'd0);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_div_d     = tx_div_q;
        tx_shift_d   = tx_shift_q;
        tx_bit_d     = tx_bit_q;
        tx_par_d     = tx_par_q;
        tx_par_en_d  = tx_par_en_q;
        tx_stop2_d   = tx_stop2_q;
        serial_out_d = serial_out_q;
        tx_pop       = 1'b0;
        tx_done      = 1'b0;

        if (tx_state_q != TX_IDLE && !tx_tick) tx_cnt_d = tx_cnt_q - 16'd1;

        case (tx_state_q)
            TX_START: if (tx_tick) begin
                tx_state_d   = TX_DATA;
                serial_out_d = tx_shift_q[0];
                tx_bit_d     = '0;
                tx_cnt_d     = tx_div_q - 16'd1;
            end
            TX_DATA: if (tx_tick) begin
                tx_cnt_d = tx_div_q - 16'd1;
                if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                    tx_state_d   = tx_par_en_q ? TX_PARITY : TX_STOP1;
                    serial_out_d = tx_par_en_q ? tx_par_q : 1'b1;
                end else begin
                    tx_bit_d     = tx_bit_q + BW'(1);
                    tx_shift_d   = tx_shift_q >> 1;
                    serial_out_d = tx_shift_q[1];
                end
            end
            TX_PARITY: if (tx_tick) begin
                tx_state_d   = TX_STOP1;
                serial_out_d = 1'b1;
                tx_cnt_d     = tx_div_q - 16'd1;
            end
            TX_STOP1: if (tx_tick) begin
                if (tx_stop2_q) begin
                    tx_state_d = TX_STOP2;
                    tx_cnt_d   = tx_div_q - 16'd1;
                end else begin
                    tx_done = 1'b1;
                end
            end
            TX_STOP2: if (tx_tick) tx_done = 1'b1;
            default: ;
        endcase

        // Loading straight out of the last stop bit gives back-to-back frames
        // with no idle gap; configuration is captured here for the whole frame.
        if (tx_state_q == TX_IDLE || tx_done) begin
            if (!tx_empty) begin
                tx_pop       = 1'b1;
                tx_state_d   = TX_START;
                serial_out_d = 1'b0;
                tx_div_d     = div_eff;
                tx_cnt_d     = div_eff - 16'd1;
                tx_shift_d   = tx_head;
                tx_par_d     = (^tx_head) ^ parity_odd;
                tx_par_en_d  = parity_en;
                tx_stop2_d   = stop2;
            end else if (tx_done) begin
                tx_state_d   = TX_IDLE;
                serial_out_d = 1'b1;
            end
        end
    end

    assign tx_wr_d    = tx_wr_q + (TXA + 1)'(tx_push);
    assign tx_rd_d    = tx_rd_q + (TXA + 1)'(tx_pop);
    assign tx_busy    = ~tx_empty | (tx_state_q != TX_IDLE);
    assign serial_out = serial_out_q;

    // ------------------------------------------------------------------
    // RX synchroniser and frame FSM
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], serial_in};
    assign rx_s   = sync_q[SYNC_STAGES-1];

    rx_state_e            rx_state_q, rx_state_d;
    logic [15:0]          rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_word_q, rx_word_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic                 rx_acc_q, rx_acc_d, rx_bad_q, rx_bad_d;
    logic                 rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
    logic                 push_q, push_d;
    logic                 rx_tick, par_set, frm_set;

    assign rx_tick = (rx_cnt_q == 16'd0);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_div_d    = rx_div_q;
        rx_shift_d  = rx_shift_q;
        rx_word_d   = rx_word_q;
        rx_bit_d    = rx_bit_q;
        rx_acc_d    = rx_acc_q;
        rx_bad_d    = rx_bad_q;
        rx_par_en_d = rx_par_en_q;
        rx_odd_d    = rx_odd_q;
        push_d      = 1'b0;
        par_set     = 1'b0;
        frm_set     = 1'b0;

        if (rx_state_q != RX_IDLE && rx_state_q != RX_BREAK && !rx_tick)
            rx_cnt_d = rx_cnt_q - 16'd1;

        case (rx_state_q)
            // IDLE is only re-entered with the line high, so a low level here
            // is the falling edge of a start bit.
            RX_IDLE: if (!rx_s) begin
                rx_state_d  = RX_START;
                rx_div_d    = div_eff;
                rx_cnt_d    = (div_eff >> 1) - 16'd1;
                rx_par_en_d = parity_en;
                rx_odd_d    = parity_odd;
            end
            RX_START: if (rx_tick) begin
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = rx_div_q - 16'd1;
                    rx_bit_d   = '0;
                    rx_acc_d   = 1'b0;
                    rx_bad_d   = 1'b0;
                end
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                rx_acc_d   = rx_acc_q ^ rx_s;
                rx_cnt_d   = rx_div_q - 16'd1;
                if (rx_bit_q == BW'(DATA_BITS - 1))
                    rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                else
                    rx_bit_d = rx_bit_q + BW'(1);
            end
            RX_PARITY: if (rx_tick) begin
                rx_bad_d   = (rx_s != (rx_acc_q ^ rx_odd_q));
                par_set    = rx_bad_d;
                rx_state_d = RX_STOP;
                rx_cnt_d   = rx_div_q - 16'd1;
            end
            RX_STOP: if (rx_tick) begin
                if (!rx_s) begin
                    frm_set    = 1'b1;
                    rx_state_d = RX_BREAK;
                end else begin
                    rx_state_d = RX_IDLE;
                    if (!rx_bad_q) begin
                        push_d    = 1'b1;
                        rx_word_d = rx_shift_q;
                    end
                end
            end
            RX_BREAK: if (rx_s) rx_state_d = RX_IDLE;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO, first-word fall-through
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] rx_mem_q [RX_DEPTH];
    logic [RXA:0]         rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic                 rx_empty, rx_full, rx_pop, rx_wr_en, ovr_set;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = ({~rx_wr_q[RXA], rx_wr_q[RXA-1:0]} == rx_rd_q);
    assign rx_valid = ~rx_empty;
    assign rx_level = rx_wr_q - rx_rd_q;
    assign rx_pop   = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign rx_wr_en = push_q & (~rx_full | rx_pop);
    assign ovr_set  = push_q & rx_full & ~rx_pop;
    assign rx_wr_d  = rx_wr_q + (RXA + 1)'(rx_wr_en);
    assign rx_rd_d  = rx_rd_q + (RXA + 1)'(rx_pop);
    assign rx_data  = rx_valid ? rx_mem_q[rx_rd_q[RXA-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rx_wr_en) rx_mem_q[rx_wr_q[RXA-1:0]] <= rx_word_q;
    end

    // Sticky flags: a set in the same cycle as err_clr wins.
    logic par_err_q, par_err_d, frm_err_q, frm_err_d, ovr_err_q, ovr_err_d;

    assign par_err_d = par_set | (par_err_q & ~err_clr);
    assign frm_err_d = frm_set | (frm_err_q & ~err_clr);
    assign ovr_err_d = ovr_set | (ovr_err_q & ~err_clr);
    assign par_err   = par_err_q;
    assign frm_err   = frm_err_q;
    assign ovr_err   = ovr_err_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_div_q     <= 16'd4;
            tx_shift_q   <= '0;
            tx_bit_q     <= '0;
            tx_par_q     <= 1'b0;
            tx_par_en_q  <= 1'b0;
            tx_stop2_q   <= 1'b0;
            serial_out_q <= 1'b1;
            sync_q       <= '1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_div_q     <= 16'd4;
            rx_shift_q   <= '0;
            rx_word_q    <= '0;
            rx_bit_q     <= '0;
            rx_acc_q     <= 1'b0;
            rx_bad_q     <= 1'b0;
            rx_par_en_q  <= 1'b0;
            rx_odd_q     <= 1'b0;
            push_q       <= 1'b0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            ovr_err_q    <= 1'b0;
        end else begin
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_div_q     <= tx_div_d;
            tx_shift_q   <= tx_shift_d;
            tx_bit_q     <= tx_bit_d;
            tx_par_q     <= tx_par_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_stop2_q   <= tx_stop2_d;
            serial_out_q <= serial_out_d;
            sync_q       <= sync_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_div_q     <= rx_div_d;
            rx_shift_q   <= rx_shift_d;
            rx_word_q    <= rx_word_d;
            rx_bit_q     <= rx_bit_d;
            rx_acc_q     <= rx_acc_d;
            rx_bad_q     <= rx_bad_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_odd_q     <= rx_odd_d;
            push_q       <= push_d;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            ovr_err_q    <= ovr_err_d;
        end
    end

endmodule

// File: doc/uart_ext.md
# uart_ext

Parametrised full-duplex UART for the SoC peripheral bus. It extends the fixed 8N1 design with several additions: a runtime baud divisor, 5–8 data bits, optional even/odd parity, one or two stop bits, TX and RX FIFOs, a metastability synchroniser and sticky error flags. It sits between the core-side ready/valid ports and the board serial pins.

## Interface
- DATA_BITS, 8, frame data width, legal 5..8
- TX_DEPTH, 8, TX FIFO entries, power of 2, ≥2
- RX_DEPTH, 8, RX FIFO entries, power of 2, ≥2
- SYNC_STAGES, 2, serial_in synchroniser flops, ≥2
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- baud_div  in  16  clocks per bit; values <4 are treated as 4
- parity_en  in  1  append/check parity bit
- parity_odd  in  1  1=odd parity, 0=even parity
- stop2  in  1  TX emits two stop bits
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX FIFO not full
- rx_data  out  DATA_BITS  head of RX FIFO
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  consumer pops head
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
- tx_busy  out  1  TX FIFO non-empty or frame in flight
- par_err, frm_err, ovr_err  out  1 each  sticky error flags
- err_clr  in  1  single-cycle pulse that clears all error flags
- serial_in  in  1  async RX pin, idle high
- serial_out  out  1  registered TX pin, idle high

## Operation
- Reset values: serial_out=1, tx_ready=1, rx_valid=0, levels=0, tx_busy=0, all errors=0, rx_data=0. Synchroniser flops reset to 1. Reset mid-frame aborts the frame and empties both FIFOs.
- Config inputs are sampled at frame start: TX at the start bit, RX at start-bit detection. Changes mid-frame do not affect the frame in flight.
- Frame format: start(0), data LSB first, optional parity, stop(1) ×1 or ×2. Even parity bit = XOR of data bits; odd parity bit = its inverse.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if !parity_en) → STOP1 → STOP2 (only if stop2) → IDLE.
  - Each state lasts baud_div cycles.
  - The FSM pops the FIFO in IDLE when the FIFO is non-empty.
  - Back-to-back frames have no idle gap.
- TX FIFO write: tx_valid && tx_ready. A write while full is impossible because tx_ready=0.
- RX FSM states: IDLE → START → DATA → PARITY (skipped if !parity_en) → STOP → IDLE.
  - IDLE: a synchronised falling edge starts a half-period count.
  - START: the line is resampled at mid-bit. If it is high, this is a false start and the FSM returns to IDLE.
  - Data, parity and stop bits are sampled at bit centres, every baud_div cycles after the start-bit centre.
  - RX checks one stop bit only.
- Bad frames:
  - Parity mismatch: par_err=1, frame dropped.
  - Stop bit sampled 0: frm_err=1, frame dropped. RX waits for the line to go high before re-arming IDLE.
- Good frame with RX FIFO full: ovr_err=1, new byte dropped; FIFO contents unchanged.
- Error flags: set and err_clr in the same cycle → set wins.
- RX FIFO is first-word fall-through: rx_data is valid whenever rx_valid=1, and the pop is rx_valid && rx_ready. Push and pop in the same cycle while full is allowed; the level stays the same and no overrun is flagged.
- Bits narrower than 8: rx_data is right-aligned; unused tx_data bits are ignored.

## Timing
- tx_ready and rx_valid are derived from registered FIFO pointers; there is no combinational path from tx_valid or rx_ready.
- TX latency: a write accepted in cycle N into an empty FIFO with TX idle produces the start-bit edge on serial_out at cycle N+2.
- RX latency: rx_valid rises 2 cycles after the stop-bit centre sample, plus SYNC_STAGES cycles of pin-to-FSM delay.
- Bit period is exactly baud_div cycles; there is no cumulative drift within a frame.
- Level counters update the cycle after a push or pop.

## Test plan
- Loopback (serial_out→serial_in), baud_div=16, 8N1, write 0xA5 → serial_out sequence 0,1,0,1,0,0,1,0,1,1 with each bit 16 cycles; rx_data=0xA5, no errors.
- parity_en=1: send 0x03 even → parity bit 0; odd → parity bit 1. Force the wrong parity on serial_in → par_err=1, rx_valid stays 0, err_clr clears it.
- Drive a frame with stop bit=0 → frm_err=1, no byte pushed. The next valid frame 0x5A is received correctly.
- RX_DEPTH=4, rx_ready=0, send 5 frames → rx_level=4, ovr_err=1, popped bytes are the first four sent.
- 3-cycle low glitch on serial_in, baud_div=16 → no byte, no errors, RX returns to IDLE.
- Fill TX FIFO (tx_ready=0 at level 8); assert rst during data bit 3 → serial_out=1 asynchronously, tx_level=0, tx_busy=0.
